// File: rtl/int_div_controller.sv
// Multi-cycle unsigned restoring divider sequencer: one quotient bit per cycle,
// valid/ready on both operand and result sides, zero-divisor result flagged.
module int_div_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_acc_q, quo_acc_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     divisor_ext;
    logic               agtb;
    logic               unused_rem_msb;

    // Partial remainder stays below the divisor between steps, so its MSB is always zero.
    assign unused_rem_msb = rem_q[WIDTH];

    assign trial       = {rem_q[WIDTH-1:0], dvd_q[cnt_q]};
    assign divisor_ext = {1'b0, dvs_q};

    Comparator #(
        .WIDTH(WIDTH + 1)
    ) u_cmp (
        .A    (divisor_ext),
        .B    (trial),
        .AGTB (agtb)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            quo_acc_q   <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_acc_q   <= quo_acc_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_acc_d   = quo_acc_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    dvd_d = Dividend;
                    dvs_d = Divisor;
                    if (Divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = Dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        rem_d     = '0;
                        quo_acc_d = '0;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        dbz_d     = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (!agtb) begin
                    rem_d            = trial - divisor_ext;
                    quo_acc_d[cnt_q] = 1'b1;
                end else begin
                    rem_d = trial;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = quo_acc_d;
                    remainder_d = rem_d[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                // Zero-divisor results raise OutValid one edge after entering DONE.
                out_valid_d = 1'b1;
                if (out_valid_q && OutReady) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign InReady   = (state_q == ST_IDLE) && !Rst;
    assign Busy      = (state_q != ST_IDLE);
    assign OutValid  = out_valid_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivByZero = dbz_q;

endmodule

// Unsigned magnitude comparator used for the per-step trial decision.
module Comparator #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             AGTB
);
    assign AGTB = (A > B);
endmodule
